// File: rtl/config_loader.sv
// config_loader
//
// Streams configuration words from a host into the fabric configuration
// chain one bit per cycle, and in the same shifts collects the bits that
// fall out of the far end of the chain into a read-back word stream.
//
// Ports
//   config_clock   : only clock, rising edge
//   config_nreset  : asynchronous active-low reset
//   start          : begin a load (sampled only in IDLE)
//   wr_data/wr_valid/wr_ready : configuration word stream in, LSB sent first
//   rd_data/rd_valid/rd_ready : read-back word stream out, first bit in LSB
//   chain_in       : serial data to the first tile's config_in
//   chain_enable   : shift enable shared by all tiles
//   chain_out      : serial data from the last tile's config_out
//   busy           : load in progress (cycle after start until done)
//   done           : one-cycle pulse at the end of a load
//   dbg_state      : current controller state (0 idle, 1 load, 2 finish)
//
// Handshakes: a word moves on a rising edge where valid and ready are both
// high. A source holds valid (and its data) stable until that edge; ready
// never depends combinationally on valid.
module config_loader #(
  parameter int WORD_WIDTH   = 32,
  parameter int CHAIN_LENGTH = 216
) (
  input  logic                  config_clock,
  input  logic                  config_nreset,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [WORD_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic                  chain_in,
  output logic                  chain_enable,
  input  logic                  chain_out,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            dbg_state
);

  localparam int NWORDS    = (CHAIN_LENGTH + WORD_WIDTH - 1) / WORD_WIDTH;
  localparam int LAST_BITS = CHAIN_LENGTH - (NWORDS - 1) * WORD_WIDTH;
  localparam int BCW       = $clog2(CHAIN_LENGTH + 1);
  localparam int WCW       = $clog2(NWORDS + 1);
  localparam int SCW       = $clog2(WORD_WIDTH + 1);

  localparam logic [BCW-1:0] BITS_TOTAL  = BCW'(CHAIN_LENGTH);
  localparam logic [WCW-1:0] WORDS_TOTAL = WCW'(NWORDS);
  localparam logic [WCW-1:0] WORDS_LAST  = WCW'(NWORDS - 1);
  localparam logic [SCW-1:0] FULL_CNT    = SCW'(WORD_WIDTH);
  localparam logic [SCW-1:0] LAST_CNT    = SCW'(LAST_BITS);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;    // bits shifted (and captured)
  logic [WCW-1:0]        wr_cnt_q, wr_cnt_d;      // words accepted
  logic [WCW-1:0]        rd_cnt_q, rd_cnt_d;      // words delivered
  logic [WORD_WIDTH-1:0] hold_q, hold_d;          // write holding register
  logic [SCW-1:0]        hold_cnt_q, hold_cnt_d;  // valid bits in hold (0 = empty)
  logic [WORD_WIDTH-1:0] tx_q, tx_d;              // transmit shift register
  logic [SCW-1:0]        tx_cnt_q, tx_cnt_d;      // bits left to send from tx
  logic [WORD_WIDTH-1:0] rx_q, rx_d;              // receive shift register
  logic [SCW-1:0]        rx_cnt_q, rx_cnt_d;      // bits collected in rx
  logic [WORD_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  chain_in_q, chain_in_d;
  logic                  chain_en_q, chain_en_d;

  logic                  wr_fire;
  logic                  rd_fire;
  logic [SCW-1:0]        wr_bits;
  logic                  src_avail;
  logic [WORD_WIDTH-1:0] rx_tmp;
  logic [SCW-1:0]        rx_cnt_tmp;
  logic [BCW-1:0]        bits_tmp;

  // State register and datapath flops
  always_ff @(posedge config_clock or negedge config_nreset) begin
    if (!config_nreset) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      hold_q     <= '0;
      hold_cnt_q <= '0;
      tx_q       <= '0;
      tx_cnt_q   <= '0;
      rx_q       <= '0;
      rx_cnt_q   <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      chain_in_q <= 1'b0;
      chain_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      hold_q     <= hold_d;
      hold_cnt_q <= hold_cnt_d;
      tx_q       <= tx_d;
      tx_cnt_q   <= tx_cnt_d;
      rx_q       <= rx_d;
      rx_cnt_q   <= rx_cnt_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      chain_in_q <= chain_in_d;
      chain_en_q <= chain_en_d;
    end
  end

  // Next-state logic. The last read word can only exist after the final bit
  // was captured, so its acceptance ends the load.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_LOAD;
      S_LOAD:   if (rd_fire && (rd_cnt_q == WORDS_LAST) && (bit_cnt_q == BITS_TOTAL))
                  state_d = S_FINISH;
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy         = (state_q != S_IDLE);
    done         = (state_q == S_FINISH);
    wr_ready     = (state_q == S_LOAD) && (hold_cnt_q == '0) && (wr_cnt_q < WORDS_TOTAL);
    rd_valid     = rd_valid_q;
    rd_data      = rd_data_q;
    chain_in     = chain_in_q;
    chain_enable = chain_en_q;
    dbg_state    = state_q;
  end

  assign wr_fire   = wr_valid && wr_ready;
  assign rd_fire   = rd_valid_q && rd_ready;
  // The last word of a load only carries the bits that still fit the chain.
  assign wr_bits   = (wr_cnt_q == WORDS_LAST) ? LAST_CNT : FULL_CNT;
  assign src_avail = (tx_cnt_q != '0) || (hold_cnt_q != '0) || wr_fire;

  // Datapath
  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    wr_cnt_d   = wr_cnt_q;
    rd_cnt_d   = rd_cnt_q;
    hold_d     = hold_q;
    hold_cnt_d = hold_cnt_q;
    tx_d       = tx_q;
    tx_cnt_d   = tx_cnt_q;
    rx_d       = rx_q;
    rx_cnt_d   = rx_cnt_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_valid_q;
    chain_in_d = 1'b0;
    chain_en_d = 1'b0;
    rx_tmp     = rx_q;
    rx_cnt_tmp = rx_cnt_q;
    bits_tmp   = bit_cnt_q;

    if (state_q == S_IDLE) begin
      if (start) begin
        bit_cnt_d  = '0;
        wr_cnt_d   = '0;
        rd_cnt_d   = '0;
        hold_cnt_d = '0;
        tx_cnt_d   = '0;
        rx_d       = '0;
        rx_cnt_d   = '0;
        rd_valid_d = 1'b0;
      end
    end else if (state_q == S_LOAD) begin
      if (wr_fire) wr_cnt_d = wr_cnt_q + 1'b1;
      if (rd_fire) begin
        rd_cnt_d   = rd_cnt_q + 1'b1;
        rd_valid_d = 1'b0;
      end

      // The chain shifts on this edge: take the bit leaving its far end.
      // Bits are placed by index so a short final word stays right-aligned.
      if (chain_en_q) begin
        rx_tmp     = rx_q | (WORD_WIDTH'(chain_out) << rx_cnt_q);
        rx_cnt_tmp = rx_cnt_q + 1'b1;
        bits_tmp   = bit_cnt_q + 1'b1;
      end
      bit_cnt_d = bits_tmp;
      rx_d      = rx_tmp;
      rx_cnt_d  = rx_cnt_tmp;

      // Hand a complete (or final partial) word over once rd_data is free.
      if (((rx_cnt_tmp == FULL_CNT) || ((bits_tmp == BITS_TOTAL) && (rx_cnt_tmp != '0)))
          && (!rd_valid_q || rd_ready)) begin
        rd_data_d  = rx_tmp;
        rd_valid_d = 1'b1;
        rx_d       = '0;
        rx_cnt_d   = '0;
      end

      // Present the next stream bit only if the receive side can take the
      // bit that will come out when it shifts. Sources in stream order:
      // transmit register, holding register, then a word arriving right now.
      if (src_avail && (rx_cnt_d != FULL_CNT)) begin
        chain_en_d = 1'b1;
        if (tx_cnt_q != '0) begin
          chain_in_d = tx_q[0];
          tx_d       = tx_q >> 1;
          tx_cnt_d   = tx_cnt_q - 1'b1;
        end else if (hold_cnt_q != '0) begin
          chain_in_d = hold_q[0];
          tx_d       = hold_q >> 1;
          tx_cnt_d   = hold_cnt_q - 1'b1;
          hold_cnt_d = '0;
        end else begin
          chain_in_d = wr_data[0];
          tx_d       = wr_data >> 1;
          tx_cnt_d   = wr_bits - 1'b1;
        end
      end

      // A word that did not go straight onto the chain parks in the hold.
      if (wr_fire && !(chain_en_d && (tx_cnt_q == '0) && (hold_cnt_q == '0))) begin
        hold_d     = wr_data;
        hold_cnt_d = wr_bits;
      end
    end
  end

endmodule

// File: doc/config_loader.md
# config_loader

Bitstream loader for the fabric configuration chain, clocked on the configuration clock. It accepts configuration words from a host-side valid/ready stream and serializes them onto the chain's serial input, driving the shared shift enable. In the same shifts it captures the bits leaving the far end of the chain and returns them as a read-back word stream. It sits between the bitstream source and the first tile's `config_in`. The last tile's `config_out` loops back to it.

## Interface
- `WORD_WIDTH`, 32: bits per write/read word.
- `CHAIN_LENGTH`, 216: total bits in the configuration chain. Must be ≥ 1.
- Derived `NWORDS` = ceil(`CHAIN_LENGTH`/`WORD_WIDTH`).

- `config_clock` input 1: the only clock. All logic is on the rising edge.
- `config_nreset` input 1: asynchronous, active-low reset.
- `start` input 1: begins a load when sampled high in IDLE. Ignored otherwise.
- `wr_data` input `WORD_WIDTH`: configuration word. Bits are sent LSB first.
- `wr_valid` input 1, `wr_ready` output 1: write handshake. Transfer occurs when both are high at the edge.
- `rd_data` output `WORD_WIDTH`: read-back word. The first bit shifted out is in the LSB.
- `rd_valid` output 1, `rd_ready` input 1: read handshake.
- `chain_in` output 1: drives the first tile's `config_in`.
- `chain_enable` output 1: drives `config_enable` of all tiles.
- `chain_out` input 1: from the last tile's `config_out`.
- `busy` output 1: high from the cycle after an accepted `start` until `done`.
- `done` output 1: one-cycle pulse when the load completes.

## Operation
- States:
  - IDLE: `start` → LOAD.
  - LOAD: when the bit count reaches `CHAIN_LENGTH` and the read side drains → FINISH.
  - FINISH: asserts `done` for one cycle → IDLE.
- Counters are cleared on entry to LOAD:
  - bit counter, 0..`CHAIN_LENGTH`;
  - write-word counter, 0..`NWORDS`;
  - read-word counter, 0..`NWORDS`.
- Write side:
  - A one-word holding register feeds a transmit shift register.
  - `wr_ready` = LOAD and holding register empty and write-word counter < `NWORDS`.
  - Exactly `NWORDS` words are accepted per load.
  - In the last word, bits above position (`CHAIN_LENGTH`−1) mod `WORD_WIDTH` are ignored.
- Shift rule:
  - `chain_enable` and `chain_in` are registered.
  - `chain_enable` is high only in a cycle where `chain_in` carries a valid stream bit and the receive side has room.
  - On that edge the chain shifts, and the loader captures `chain_out` into the receive shift register.
  - Stream bit i ends at chain position `CHAIN_LENGTH`−1−i.
- Read side:
  - A receive shift register feeds a one-word `rd_data` holding register.
  - A word moves to `rd_data` when `WORD_WIDTH` bits have been collected, or when the final bit of the load arrives. In the second case the unused upper bits are zero.
  - `rd_valid` stays high until accepted.
  - If the receive register is full and `rd_data` is still held, `chain_enable` drops. No bit is ever shifted without being captured.
- The read-back stream of a load equals the write stream of the previous load into the same chain, with unused upper bits of the last word zeroed.
- `start` while `busy` is ignored. `wr_valid` outside LOAD is ignored.

## Timing
- Reset values:
  - all outputs 0: `wr_ready`, `rd_valid`, `rd_data`, `chain_in`, `chain_enable`, `busy`, `done`;
  - state IDLE, counters 0.
- Reset mid-load:
  - returns the block to IDLE immediately;
  - `chain_enable` falls asynchronously;
  - chain contents are undefined unless the chain is reset too (it shares `config_nreset`).
- `start` sampled in cycle 0 → `busy` and `wr_ready` high in cycle 1.
- A write accepted at the end of cycle a → `chain_enable` = 1 with that word's bit 0 on `chain_in` in cycle a+1, if the receive side has room.
- Sustained throughput is 1 bit/cycle with no bubble at word boundaries, provided `wr_valid` and `rd_ready` are held high.
- Final bit shifted in cycle f → last read word has `rd_valid` high in cycle f+1.
- Last read word accepted in cycle r → `done` = 1 in cycle r+1, and `busy` = 0 from cycle r+2.

## Test plan
Bench uses `WORD_WIDTH`=8 and `CHAIN_LENGTH`=24, with one real tile shift register on the chain, unless a scenario says otherwise.

1. Reset:
   - Assert `config_nreset`=0 mid-idle → all outputs 0.
   - Release, pulse `start` → `busy`=1 and `wr_ready`=1 one cycle later.
2. Basic load into a freshly reset tile:
   - Write 0x01, 0x00, 0x80 back-to-back with `rd_ready`=1.
   - → exactly 24 contiguous `chain_enable` cycles;
   - → tile register = 0x800001;
   - → read words 0x00, 0x00, 0x00;
   - → one `done` pulse.
3. Read-back:
   - Immediately reload with 0x00, 0x00, 0x00.
   - → read words 0x01, 0x00, 0x80;
   - → tile register = 0x000000.
4. Backpressure:
   - Hold `rd_ready`=0 after the first read word.
   - → `chain_enable` falls after 16 enabled shifts total and stays low.
   - Release `rd_ready` → shifting resumes; final tile state and read words match scenario 3.
5. Write starvation:
   - Insert 5-cycle gaps in `wr_valid`.
   - → `chain_enable` is low during the gaps; enabled-cycle count is still 24; results are identical to scenario 2.
6. Edge cases, with `CHAIN_LENGTH`=20:
   - Write 0xFF ×3 → only 20 enables; last read word has bits 7:4 = 0.
   - `start` while `busy` → no effect.
   - Reset asserted after 10 shifts → immediate IDLE; a new load then completes correctly.
